// File: rtl/md_seq.sv
// Multiply/divide sequencer for the EX stage: launches the external multiplier
// or divider, stalls the front of the pipe while the op runs, and holds the HI/LO result.
module md_seq #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [4:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        advance,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        busy_q, busy_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] mul_ina_q, mul_ina_d;
    logic [31:0] mul_inb_q, mul_inb_d;
    logic        mul_signed_q, mul_signed_d;
    logic [31:0] div_op1_q, div_op1_d;
    logic [31:0] div_op2_q, div_op2_d;
    logic        div_signed_q, div_signed_d;

    logic        op_one_hot;
    logic        is_mul;
    logic        is_div;
    logic        stall_c;
    logic        annul_c;

    // op is {mul, mult, multu, div, divu}; anything but exactly one bit is a no-op
    always_comb begin
        op_one_hot = (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
        is_mul     = op_one_hot && (|op[4:2]);
        is_div     = op_one_hot && (|op[1:0]);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = 1'b0;
        res_hi_d     = res_hi_q;
        res_lo_d     = res_lo_q;
        mul_ina_d    = mul_ina_q;
        mul_inb_d    = mul_inb_q;
        mul_signed_d = mul_signed_q;
        div_op1_d    = div_op1_q;
        div_op2_d    = div_op2_q;
        div_signed_d = div_signed_q;
        stall_c      = 1'b0;
        annul_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush && op_valid) begin
                    if (is_mul) begin
                        mul_ina_d    = src1;
                        mul_inb_d    = src2;
                        mul_signed_d = op[4] | op[3];
                        cnt_d        = CNT_LOAD;
                        state_d      = MUL_WAIT;
                        stall_c      = 1'b1;
                    end else if (is_div) begin
                        stall_c = 1'b1;
                        if (src2 != 32'd0) begin
                            div_op1_d    = src1;
                            div_op2_d    = src2;
                            div_signed_d = op[1];
                            first_d      = 1'b1;
                            state_d      = DIV_WAIT;
                        end else begin
                            // Divide by zero never reaches the divider
                            res_hi_d = src1;
                            res_lo_d = 32'hFFFF_FFFF;
                            state_d  = DONE;
                        end
                    end
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == 3'd0) begin
                        res_hi_d = mul_result[63:32];
                        res_lo_d = mul_result[31:0];
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            DIV_WAIT: begin
                if (flush) begin
                    annul_c = 1'b1;
                    state_d = IDLE;
                end else if (div_ready) begin
                    res_hi_d = div_result[63:32];
                    res_lo_d = div_result[31:0];
                    state_d  = DONE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            DONE: begin
                if (flush || advance) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            first_q      <= 1'b0;
            busy_q       <= 1'b0;
            res_hi_q     <= 32'd0;
            res_lo_q     <= 32'd0;
            mul_ina_q    <= 32'd0;
            mul_inb_q    <= 32'd0;
            mul_signed_q <= 1'b0;
            div_op1_q    <= 32'd0;
            div_op2_q    <= 32'd0;
            div_signed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            busy_q       <= busy_d;
            res_hi_q     <= res_hi_d;
            res_lo_q     <= res_lo_d;
            mul_ina_q    <= mul_ina_d;
            mul_inb_q    <= mul_inb_d;
            mul_signed_q <= mul_signed_d;
            div_op1_q    <= div_op1_d;
            div_op2_q    <= div_op2_d;
            div_signed_q <= div_signed_d;
        end
    end

    // Reset masks every control output in the same cycle, including a pending annul
    assign stallreq   = stall_c && !rst;
    assign div_annul  = annul_c && !rst;
    assign div_start  = (state_q == DIV_WAIT) && first_q && !rst;
    assign res_valid  = (state_q == DONE) && !rst;
    assign busy       = busy_q && !rst;

    assign res_hi     = res_hi_q;
    assign res_lo     = res_lo_q;
    assign mul_ina    = mul_ina_q;
    assign mul_inb    = mul_inb_q;
    assign mul_signed = mul_signed_q;
    assign div_op1    = div_op1_q;
    assign div_op2    = div_op2_q;
    assign div_signed = div_signed_q;

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: stimulus pushes hand-computed HI/LO results,
// a negedge monitor pops and compares each time res_valid rises.
module tb_md_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        advance = 1'b1;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_annul, div_signed;
    logic [31:0] div_op1, div_op2;
    logic        div_ready = 1'b0;
    logic [63:0] div_result = 64'd0;
    logic        stallreq, res_valid, busy;
    logic [31:0] res_hi, res_lo;

    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_DIV   = 5'b00010;
    localparam logic [4:0] OP_DIVU  = 5'b00001;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    md_seq #(.MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
        .src1(src1), .src2(src2), .advance(advance),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_op1(div_op1), .div_op2(div_op2), .div_ready(div_ready),
        .div_result(div_result),
        .stallreq(stallreq), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product of the registered operands
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    assign sprod = $signed(mul_ina) * $signed(mul_inb);
    assign uprod = {32'd0, mul_ina} * {32'd0, mul_inb};
    assign mul_result = mul_signed ? sprod : uprod;

    // Divider stand-in: result ready 33 cycles after the start pulse
    logic       dv_active = 1'b0;
    int         dv_cnt = 0;
    logic signed [31:0] sq, sr;
    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (rst || div_annul) begin
            dv_active <= 1'b0;
        end else if (div_start) begin
            dv_active <= 1'b1;
            dv_cnt    <= 33;
            if (div_signed) begin
                sq = $signed(div_op1) / $signed(div_op2);
                sr = $signed(div_op1) % $signed(div_op2);
                div_result <= {sr, sq};
            end else begin
                div_result <= {div_op1 % div_op2, div_op1 / div_op2};
            end
        end else if (dv_active) begin
            if (dv_cnt == 1) begin
                div_ready <= 1'b1;
                dv_active <= 1'b0;
            end
            dv_cnt <= dv_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per result presented
    logic prev_valid = 1'b0;
    int   n_res = 0;
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result", {res_hi, res_lo}, e);
                $display("result %0d: hi=%h lo=%h expected %h", n_res, res_hi, res_lo, e);
                n_res++;
            end
        end
        prev_valid = res_valid;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0;
        op = 5'd0;
        src1 = 32'd0;
        src2 = 32'd0;
    endtask

    // Counts stalled busy cycles until res_valid; returns in the first DONE cycle
    task automatic wait_done(input string name, output int stalls, output int starts);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        starts = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            if (stallreq && busy) stalls++;
            if (div_start) starts++;
            step();
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int stalls, starts;
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, starts;

        // Reset state
        step(); step();
        #1;
        check("rst_stallreq", 64'(stallreq), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_res", {res_hi, res_lo}, 64'd0);
        check("rst_mul_ops", {mul_ina, mul_inb}, 64'd0);
        rst = 1'b0;
        step();

        // mult -3 * 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        #1;
        check("mult_accept_stall", 64'(stallreq), 64'd1);
        step();
        idle_inputs();
        wait_done("mult", stalls, starts);
        check("mult_wait_stalls", 64'(stalls), 64'd2);
        check("mult_done_stall", 64'(stallreq), 64'd0);
        step();
        #1;
        check("mult_idle_after", 64'(busy), 64'd0);

        // Non-accepted ops: two bits set, op==0, flush with op_valid
        issue(5'b00011, 32'd9, 32'd3);
        #1;
        check("multi_bit_stall", 64'(stallreq), 64'd0);
        step();
        issue(5'd0, 32'd9, 32'd3);
        #1;
        check("multi_bit_busy", 64'(busy), 64'd0);
        check("zero_op_stall", 64'(stallreq), 64'd0);
        step();
        issue(OP_MULTU, 32'd9, 32'd3);
        flush = 1'b1;
        #1;
        check("flush_idle_stall", 64'(stallreq), 64'd0);
        step();
        flush = 1'b0;
        idle_inputs();
        #1;
        check("flush_idle_busy", 64'(busy), 64'd0);
        step();

        // divu 100 / 7 -> q=14 r=2
        issue(OP_DIVU, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        #1;
        check("divu_accept_stall", 64'(stallreq), 64'd1);
        check("divu_accept_nostart", 64'(div_start), 64'd0);
        step();
        idle_inputs();
        #1;
        check("divu_first_start", 64'(div_start), 64'd1);
        wait_done("divu", stalls, starts);
        check("divu_start_pulses", 64'(starts), 64'd1);
        // start cycle plus 33 cycles until the divider model raises ready
        check("divu_wait_stalls", 64'(stalls), 64'd34);
        check("divu_done_stall", 64'(stallreq), 64'd0);
        step();

        // div -7 / 0
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        exp_q.push_back(64'hFFFF_FFF9_FFFF_FFFF);
        #1;
        check("dz_accept_stall", 64'(stallreq), 64'd1);
        step();
        idle_inputs();
        #1;
        check("dz_done_next", 64'(res_valid), 64'd1);
        check("dz_no_start", 64'(div_start), 64'd0);
        check("dz_divider_idle", 64'(dv_active), 64'd0);
        step();

        // divu flushed on its 5th DIV_WAIT cycle, then multu accepted
        issue(OP_DIVU, 32'd50, 32'd3);
        step();
        idle_inputs();
        step(); step(); step(); step();
        flush = 1'b1;
        #1;
        check("flush_div_annul", 64'(div_annul), 64'd1);
        check("flush_div_stall", 64'(stallreq), 64'd0);
        step();
        flush = 1'b0;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        exp_q.push_back(64'h0000_0001_FFFF_FFFE);
        #1;
        check("flush_then_idle", 64'(busy), 64'd0);
        check("flush_annul_once", 64'(div_annul), 64'd0);
        check("multu_accept_stall", 64'(stallreq), 64'd1);
        step();
        idle_inputs();
        wait_done("multu", stalls, starts);
        step();

        // mul 7 * 6 held in DONE with advance low
        advance = 1'b0;
        issue(OP_MUL, 32'd7, 32'd6);
        exp_q.push_back(64'd42);
        step();
        idle_inputs();
        wait_done("mul_hold", stalls, starts);
        for (int i = 0; i < 3; i++) begin
            step();
            issue(OP_DIVU, 32'd123, 32'd5);
            #1;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_result", {res_hi, res_lo}, 64'd42);
            check("hold_stall", 64'(stallreq), 64'd0);
        end
        step();
        idle_inputs();
        advance = 1'b1;
        step();
        #1;
        check("hold_release_idle", 64'(busy), 64'd0);
        check("hold_release_valid", 64'(res_valid), 64'd0);

        // Reset in the middle of MUL_WAIT
        issue(OP_MULT, 32'd11, 32'd13);
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rstmul_stallreq", 64'(stallreq), 64'd0);
        check("rstmul_busy_now", 64'(busy), 64'd0);
        step();
        #1;
        check("rstmul_res", {res_hi, res_lo}, 64'd0);
        check("rstmul_mul_ops", {mul_ina, mul_inb}, 64'd0);
        check("rstmul_signed", 64'(mul_signed), 64'd0);
        check("rstmul_valid", 64'(res_valid), 64'd0);
        rst = 1'b0;
        step();

        // Reset in the middle of DIV_WAIT: no annul
        issue(OP_DIVU, 32'd9, 32'd2);
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        #1;
        check("rstdiv_no_annul", 64'(div_annul), 64'd0);
        step();
        #1;
        check("rstdiv_div_ops", {div_op1, div_op2}, 64'd0);
        check("rstdiv_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step(); step(); step();

        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: cycles from multiplier operand presentation to valid mul_result (range 1..7).
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  cancel the in-flight op (exception/eret).
- op_valid  in  1  EX holds a mul/div-class instruction.
- op  in  5  one-hot {mul, mult, multu, div, divu}.
- src1, src2  in  32 each  operands (rs, rt).
- advance  in  1  EX result is accepted downstream this cycle.
- mul_signed  out  1  to multiplier.
- mul_ina, mul_inb  out  32 each  registered operands to multiplier.
- mul_result  in  64  multiplier product.
- div_start  out  1  start pulse to divider.
- div_annul  out  1  abort to divider.
- div_signed  out  1  to divider.
- div_op1, div_op2  out  32 each  registered operands to divider.
- div_ready  in  1  divider result valid.
- div_result  in  64  {remainder, quotient}.
- stallreq  out  1  freeze IF..EX.
- res_valid  out  1  res_hi/res_lo valid.
- res_hi, res_lo  out  32 each  HI/LO result; mul uses res_lo only.
- busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, MUL_WAIT, DIV_WAIT, DONE.
REQ-004 IDLE + op_valid + any mul-class op: latch src1/src2 into mul_ina/mul_inb, set mul_signed = mul|mult, load counter with MUL_LAT-1, go MUL_WAIT; stallreq=1 that cycle.
REQ-005 MUL_WAIT: stallreq=1; decrement counter each cycle; at counter==0, capture mul_result into res_hi/res_lo, go DONE.
REQ-006 IDLE + op_valid + div-class op, src2 != 0: latch operands into div_op1/div_op2, div_signed = div, go DIV_WAIT; stallreq=1.
REQ-007 div_start SHALL be 1 exactly on the first DIV_WAIT cycle and 0 otherwise.
REQ-008 DIV_WAIT: stallreq=1 until div_ready=1; on div_ready capture div_result[63:32] to res_hi, [31:0] to res_lo, go DONE.
REQ-009 IDLE + div-class op, src2 == 0: divider not started; res_hi=src1, res_lo=32'hFFFF_FFFF; go DONE next cycle; stallreq=1 for that one cycle.
REQ-010 DONE: stallreq=0, res_valid=1; advance=1 -> IDLE; advance=0 -> hold DONE, results stable, no new op accepted.
REQ-011 res_valid SHALL be 0 in every state except DONE.
REQ-012 flush=1 in any state: next state IDLE, res_valid=0 next cycle, stallreq=0 in the flush cycle; flush priority over every other transition.
REQ-013 flush in DIV_WAIT: div_annul=1 for exactly that cycle; div_annul=0 in all other cases.
REQ-014 flush and op_valid in the same IDLE cycle: op not accepted.
REQ-015 op_valid=0 or op==0 in IDLE: stay IDLE, stallreq=0.
REQ-016 op with more than one bit set: treated as no-op (stay IDLE).
REQ-017 Inputs op/src1/src2 SHALL be ignored outside IDLE; latched operands drive all results.
REQ-018 busy SHALL equal (state != IDLE), registered.

Reset
REQ-019 rst=1 at posedge: state IDLE, counter 0, res_hi=res_lo=0, mul_ina/inb=0, div_op1/op2=0, mul_signed=div_signed=0.
REQ-020 While in reset: stallreq=0, res_valid=0, div_start=0, div_annul=0, busy=0.
REQ-021 rst SHALL override flush and all transitions; rst mid-DIV_WAIT returns IDLE without asserting div_annul.

Verification
REQ-022 mult src1=-3, src2=5, MUL_LAT=2, advance=1 in DONE -> stallreq high 2 cycles, then res_valid=1, {res_hi,res_lo}=64'hFFFF_FFFF_FFFF_FFF1, IDLE next cycle.
REQ-023 divu src1=100, src2=7, divider model ready after 33 cycles -> div_start pulse 1 cycle, stallreq high until ready, res_lo=14, res_hi=2.
REQ-024 div src1=-7, src2=0 -> no div_start, one stall cycle, res_hi=32'hFFFF_FFF9, res_lo=32'hFFFF_FFFF.
REQ-025 divu issued, flush on 5th DIV_WAIT cycle -> div_annul=1 that cycle, IDLE next, res_valid never asserted; new multu accepted next cycle.
REQ-026 mul in DONE with advance=0 for 3 cycles -> res_valid held 1, results stable, stallreq=0; op change ignored; advance=1 -> IDLE.
REQ-027 rst asserted mid-MUL_WAIT -> all outputs at REQ-019/020 values next cycle.
